// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter and scheduler for a 4:1 array-index mux datapath.
// Four producers each offer a W-bit word with a valid/ready handshake. One
// requester is picked per cycle, its index drives the mux select, and the
// selected word is registered into a one-entry output buffer. That buffer
// has its own valid/ready handshake towards a single shared consumer.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req_valid  in   4   req_valid[i]: requester i offers d<i>
//   req_ready  out  4   one-hot or zero: requester i's word is taken this cycle
//   d0..d3     in   W   requester data words
//   out_valid  out  1   output buffer holds a word
//   out_ready  in   1   consumer accepts out_data this cycle
//   out_data   out  W   buffered word
//   out_src    out  2   index of the requester that supplied out_data
// ----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t   state_reg, state_next;
    logic [W-1:0] data_reg,  data_next;
    logic [1:0]   src_reg,   src_next;
    logic [1:0]   lp_reg,    lp_next;

    logic [W-1:0] d_arr     [4];
    logic [1:0]   cand_idx  [4];
    logic [3:0]   cand_valid;
    logic [3:0]   cand_onehot;
    logic         grant_any;
    logic [1:0]   grant_idx;
    logic         can_accept;
    logic         transfer;

    // Word array indexed by requester number; the grant index is the mux select.
    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;

    // Candidate slot gi holds requester lp+1+gi (mod 4), so slot 0 is the
    // highest-priority requester. The 2-bit addition wraps naturally.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi]   = lp_reg + 2'(gi + 1);
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // First set slot wins: isolate the lowest set bit of the rotated vector.
    assign cand_onehot = cand_valid & (~cand_valid + 4'd1);
    assign grant_any   = |cand_valid;

    always_comb begin
        grant_idx = lp_reg;
        for (int i = 0; i < 4; i++) begin
            if (cand_onehot[i]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

    // The buffer can take a word when empty or when it is being drained in the
    // same cycle, which gives one word per cycle throughput.
    assign can_accept = (state_reg == EMPTY) || out_ready;
    assign transfer   = grant_any && can_accept;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign req_ready[gi] = transfer && (grant_idx == 2'(gi));
        end
    endgenerate

    // Next-state logic for the output buffer and the last-grant pointer.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        src_next   = src_reg;
        lp_next    = lp_reg;
        case (state_reg)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                    data_next  = d_arr[grant_idx];
                    src_next   = grant_idx;
                    lp_next    = grant_idx;
                end
            end
            FULL: begin
                if (transfer) begin
                    // Drain and refill together: new word replaces the old.
                    state_next = FULL;
                    data_next  = d_arr[grant_idx];
                    src_next   = grant_idx;
                    lp_next    = grant_idx;
                end else if (out_ready) begin
                    // Drain only: data and source keep their last values.
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // lp resets to 3 so that requester 0 has top priority first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            src_reg   <= 2'd0;
            lp_reg    <= 2'd3;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
            lp_reg    <= lp_next;
        end
    end

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_src   = src_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model state.
    logic [1:0]   m_lp;
    logic         m_full;
    logic [W-1:0] m_data;
    logic [1:0]   m_src;
    logic [W+1:0] sb[$];   // {src, data} expected for each accepted request

    rr_mux_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word(input logic [1:0] idx);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    task automatic model_reset();
        m_lp   = 2'd3;
        m_full = 1'b0;
        m_data = '0;
        m_src  = 2'd0;
        sb.delete();
    endtask

    // One clock cycle: drive at negedge, check req_ready combinationally,
    // push expected word on a modelled transfer, then check outputs after the edge.
    task automatic step(input logic [3:0] rv, input logic ro);
        logic [1:0]   g;
        logic [1:0]   idx;
        logic         found;
        logic         can;
        logic         xfer;
        logic [3:0]   exp_rdy;
        logic [W+1:0] e;
        @(negedge clk);
        req_valid = rv;
        out_ready = ro;
        #1;
        can   = !m_full || ro;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(m_lp + 2'(k));
            if (!found && rv[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        xfer    = found && can;
        exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (xfer) begin
            sb.push_back({g, word(g)});
            m_lp   = g;
            m_full = 1'b1;
        end else if (m_full && ro) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_full));
        if (xfer) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e      = sb.pop_front();
                m_src  = e[W+1:W];
                m_data = e[W-1:0];
            end
        end
        check_eq("out_src", 32'(out_src), 32'(m_src));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        $display("cyc rv=%b ro=%b rdy=%b ov=%b src=%0d data=%h",
                 rv, ro, req_ready, out_valid, out_src, out_data);
    endtask

    initial begin
        logic [1:0] t2_src [5];
        logic [3:0] t2_dat [5];
        t2_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        t2_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

        rst       = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        model_reset();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_src", 32'(out_src), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Test 2: all request, consumer always ready -> 0,1,2,3,0 back to back.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1);
            check_eq("t2_src", 32'(out_src), 32'(t2_src[i]));
            check_eq("t2_data", 32'(out_data), 32'(t2_dat[i]));
        end

        // Test 6: no requests while FULL -> drains, data retained.
        step(4'b0000, 1'b1);
        check_eq("t6_valid", 32'(out_valid), 32'd0);
        check_eq("t6_data", 32'(out_data), 32'h1);

        // Test 3: only requester 2.
        d2 = 4'hA;
        step(4'b0100, 1'b1);
        check_eq("t3_data", 32'(out_data), 32'hA);
        check_eq("t3_src", 32'(out_src), 32'd2);

        // Test 4: stall three cycles while FULL, then release.
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8;
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0);
            check_eq("t4_hold_data", 32'(out_data), 32'hA);
        end
        step(4'b1111, 1'b1);
        check_eq("t4_release_src", 32'(out_src), 32'd3);

        // Test 5: set lp=1, then 3 is served before 0, then 0.
        step(4'b0010, 1'b1);
        step(4'b1001, 1'b1);
        check_eq("t5_first", 32'(out_src), 32'd3);
        step(4'b1001, 1'b1);
        check_eq("t5_second", 32'(out_src), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            step(4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Test 1: asynchronous reset while FULL clears the buffer at once.
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        check_eq("t1_full_before", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("t1_valid", 32'(out_valid), 32'd0);
        check_eq("t1_data", 32'(out_data), 32'd0);
        check_eq("t1_src", 32'(out_src), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 1'b1);
        check_eq("t1_first_grant", 32'(out_src), 32'd0);
        check_eq("t1_first_data", 32'(out_data), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
